// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit multicycle CPU: FSM states, opcodes,
// ALU operation codes and ALU operand-B select values.
package cpu_pkg;

  localparam int OPW   = 4;
  localparam int ALUCW = 3;

  typedef logic [OPW-1:0]   opcode_t;
  typedef logic [ALUCW-1:0] alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_EXEC_I  = 4'd4,
    S_ALU_WB  = 4'd5,
    S_MEM_RD  = 4'd6,
    S_LOAD_WB = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_HALT    = 4'd11
  } state_t;

  localparam opcode_t OP_ADD  = 4'h0;
  localparam opcode_t OP_SUB  = 4'h1;
  localparam opcode_t OP_AND  = 4'h2;
  localparam opcode_t OP_OR   = 4'h3;
  localparam opcode_t OP_ADDI = 4'h4;
  localparam opcode_t OP_LB   = 4'h5;
  localparam opcode_t OP_SB   = 4'h6;
  localparam opcode_t OP_BEQZ = 4'h7;
  localparam opcode_t OP_JMP  = 4'h8;
  localparam opcode_t OP_HALT = 4'hF;

  localparam alu_op_t ALU_ADD    = 3'b000;
  localparam alu_op_t ALU_SUB    = 3'b001;
  localparam alu_op_t ALU_AND    = 3'b010;
  localparam alu_op_t ALU_OR     = 3'b011;
  localparam alu_op_t ALU_PASS_A = 3'b100;

  localparam logic [1:0] OP2_REGB = 2'b00;
  localparam logic [1:0] OP2_ONE  = 2'b01;
  localparam logic [1:0] OP2_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_controller_if;
  import cpu_pkg::*;

  opcode_t    opcode;
  logic       zero;
  logic       memEnable;
  logic       pcSelect;
  logic       pcEnable;
  logic       adrSelect;
  logic       ir1En;
  logic       ir2En;
  logic       op1Sel;
  logic [1:0] op2Sel;
  logic       regWrite;
  logic       memToReg;
  alu_op_t    aluControl;
  logic       halted;
  logic       illegalOp;

  modport master (
    input  opcode, zero,
    output memEnable, pcSelect, pcEnable, adrSelect, ir1En, ir2En,
           op1Sel, op2Sel, regWrite, memToReg, aluControl, halted, illegalOp
  );

  modport slave (
    output opcode, zero,
    input  memEnable, pcSelect, pcEnable, adrSelect, ir1En, ir2En,
           op1Sel, op2Sel, regWrite, memToReg, aluControl, halted, illegalOp
  );

endinterface

// File: rtl/alu_decoder.sv
// Maps the low two opcode bits of an R-type instruction to the ALU operation.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [1:0] i_func,
  output alu_op_t    o_alu_op
);

  always_comb begin
    o_alu_op = ALU_ADD;
    case (i_func)
      2'b00:   o_alu_op = ALU_ADD;
      2'b01:   o_alu_op = ALU_SUB;
      2'b10:   o_alu_op = ALU_AND;
      2'b11:   o_alu_op = ALU_OR;
      default: o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the 8-bit multicycle CPU: two-byte fetch, decode,
// execute and write-back. Outputs decode from the state register.
module multicycle_controller
  import cpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_t     r_state;
  state_t     w_state_next;
  alu_op_t    w_rtype_op;
  logic       w_mem_enable, w_pc_select, w_pc_enable, w_adr_select;
  logic       w_ir1_en, w_ir2_en, w_op1_sel, w_reg_write, w_mem_to_reg;
  logic       w_halted, w_illegal;
  logic [1:0] w_op2_sel;
  alu_op_t    w_alu_ctrl;

  alu_decoder u_alu_decoder (
    .i_func   (bus.opcode[1:0]),
    .o_alu_op (w_rtype_op)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH1;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_mem_enable = 1'b0;
    w_pc_select  = 1'b0;
    w_pc_enable  = 1'b0;
    w_adr_select = 1'b0;
    w_ir1_en     = 1'b0;
    w_ir2_en     = 1'b0;
    w_op1_sel    = 1'b0;
    w_op2_sel    = OP2_REGB;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_ctrl   = ALU_ADD;
    w_halted     = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH1: begin
        w_ir1_en     = 1'b1;
        w_op2_sel    = OP2_ONE;
        w_pc_enable  = 1'b1;
        w_state_next = S_FETCH2;
      end
      S_FETCH2: begin
        w_ir2_en     = 1'b1;
        w_op2_sel    = OP2_ONE;
        w_pc_enable  = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: w_state_next = S_EXEC_R;
          OP_ADDI: w_state_next = S_EXEC_I;
          OP_LB:   w_state_next = S_MEM_RD;
          OP_SB:   w_state_next = S_MEM_WR;
          OP_BEQZ: w_state_next = S_BRANCH;
          OP_JMP:  w_state_next = S_JUMP;
          OP_HALT: w_state_next = S_HALT;
          default: begin
            w_illegal    = 1'b1;
            w_state_next = S_FETCH1;
          end
        endcase
      end
      S_EXEC_R: begin
        w_op1_sel    = 1'b1;
        w_alu_ctrl   = w_rtype_op;
        w_state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        w_op1_sel    = 1'b1;
        w_op2_sel    = OP2_IMM;
        w_state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH1;
      end
      S_MEM_RD: begin
        w_adr_select = 1'b1;
        w_state_next = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        w_adr_select = 1'b1;
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_state_next = S_FETCH1;
      end
      S_MEM_WR: begin
        w_adr_select = 1'b1;
        w_mem_enable = 1'b1;
        w_state_next = S_FETCH1;
      end
      S_BRANCH: begin
        w_op1_sel    = 1'b1;
        w_alu_ctrl   = ALU_PASS_A;
        w_pc_select  = 1'b1;
        w_pc_enable  = bus.zero;
        w_state_next = S_FETCH1;
      end
      S_JUMP: begin
        w_pc_select  = 1'b1;
        w_pc_enable  = 1'b1;
        w_state_next = S_FETCH1;
      end
      S_HALT: begin
        w_halted     = 1'b1;
        w_state_next = S_HALT;
      end
      default: w_state_next = S_FETCH1;
    endcase
  end

  // Reset gates outputs combinationally so an in-flight write is killed in the reset cycle.
  assign bus.memEnable  = w_mem_enable & ~reset;
  assign bus.pcSelect   = w_pc_select  & ~reset;
  assign bus.pcEnable   = w_pc_enable  & ~reset;
  assign bus.adrSelect  = w_adr_select & ~reset;
  assign bus.ir1En      = w_ir1_en     & ~reset;
  assign bus.ir2En      = w_ir2_en     & ~reset;
  assign bus.op1Sel     = w_op1_sel    & ~reset;
  assign bus.op2Sel     = reset ? OP2_REGB : w_op2_sel;
  assign bus.regWrite   = w_reg_write  & ~reset;
  assign bus.memToReg   = w_mem_to_reg & ~reset;
  assign bus.aluControl = reset ? ALU_ADD : w_alu_ctrl;
  assign bus.halted     = w_halted     & ~reset;
  assign bus.illegalOp  = w_illegal    & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; outputs packed into one
// 16-bit word {memEnable,pcSelect,pcEnable,adrSelect,ir1En,ir2En,op1Sel,op2Sel,
// regWrite,memToReg,aluControl,halted,illegalOp} and compared per cycle.
module tb_multicycle_controller;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] outs;
  assign outs = {bus.memEnable, bus.pcSelect, bus.pcEnable, bus.adrSelect,
                 bus.ir1En, bus.ir2En, bus.op1Sel, bus.op2Sel,
                 bus.regWrite, bus.memToReg, bus.aluControl,
                 bus.halted, bus.illegalOp};

  localparam logic [15:0] E_F1 = 16'h2880;
  localparam logic [15:0] E_F2 = 16'h2480;
  localparam logic [15:0] E_DEC = 16'h0000;

  task automatic test_reset();
    reset = 1'b1;
    bus.opcode = 4'h0;
    bus.zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_total++;
      if (outs !== 16'h0000) $display("FAIL reset_hold[%0d] got %h want %h", i, outs, 16'h0000);
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++;
    if (outs !== E_F1) $display("FAIL reset_release got %h want %h", outs, E_F1);
    else n_pass++;
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [5];
    logic [15:0] ex  [5];
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    ex  = '{16'h0200, 16'h0204, 16'h0208, 16'h020C, 16'h0300};
    for (int k = 0; k < 5; k++) begin
      logic [15:0] seq [5];
      seq = '{E_F1, E_F2, E_DEC, ex[k], 16'h0040};
      bus.opcode = ops[k];
      for (int i = 0; i < 5; i++) begin
        #1;
        n_total++;
        if (outs !== seq[i]) $display("FAIL alu_op%0h_cyc%0d got %h want %h", ops[k], i, outs, seq[i]);
        else n_pass++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_load();
    logic [15:0] seq [5];
    seq = '{E_F1, E_F2, E_DEC, 16'h1000, 16'h1060};
    bus.opcode = 4'h5;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (outs !== seq[i]) $display("FAIL load_cyc%0d got %h want %h", i, outs, seq[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [15:0] seq [5];
    seq = '{E_F1, E_F2, E_DEC, 16'h9000, E_F1};
    bus.opcode = 4'h6;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (outs !== seq[i]) $display("FAIL store_cyc%0d got %h want %h", i, outs, seq[i]);
      else n_pass++;
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      logic [15:0] seq [5];
      seq = '{E_F1, E_F2, E_DEC, (z == 1) ? 16'h6210 : 16'h4210, E_F1};
      bus.opcode = 4'h7;
      bus.zero = z[0];
      for (int i = 0; i < 5; i++) begin
        #1;
        n_total++;
        if (outs !== seq[i]) $display("FAIL beqz_z%0d_cyc%0d got %h want %h", z, i, outs, seq[i]);
        else n_pass++;
        if (i < 4) @(negedge clk);
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [15:0] seq [5];
    seq = '{E_F1, E_F2, E_DEC, 16'h6000, E_F1};
    bus.opcode = 4'h8;
    bus.zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (outs !== seq[i]) $display("FAIL jmp_cyc%0d got %h want %h", i, outs, seq[i]);
      else n_pass++;
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] seq [4];
    seq = '{E_F1, E_F2, 16'h0001, E_F1};
    bus.opcode = 4'hA;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if (outs !== seq[i]) $display("FAIL illegal_cyc%0d got %h want %h", i, outs, seq[i]);
      else n_pass++;
      if (i < 3) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] seq [3];
    seq = '{E_F1, E_F2, E_DEC};
    bus.opcode = 4'h6;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (outs !== seq[i]) $display("FAIL rstwr_cyc%0d got %h want %h", i, outs, seq[i]);
      else n_pass++;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    n_total++;
    if (outs !== 16'h0000) $display("FAIL rstwr_memwr got %h want %h", outs, 16'h0000);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    bus.opcode = 4'h0;
    #1;
    n_total++;
    if (outs !== E_F1) $display("FAIL rstwr_after got %h want %h", outs, E_F1);
    else n_pass++;
  endtask

  task automatic test_halt();
    logic [15:0] seq [3];
    seq = '{E_F1, E_F2, E_DEC};
    bus.opcode = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (outs !== seq[i]) $display("FAIL halt_fetch_cyc%0d got %h want %h", i, outs, seq[i]);
      else n_pass++;
      @(negedge clk);
    end
    bus.opcode = 4'h0;
    bus.zero = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_total++;
      if (outs !== 16'h0002) $display("FAIL halt_hold_cyc%0d got %h want %h", i, outs, 16'h0002);
      else n_pass++;
      @(negedge clk);
    end
    bus.zero = 1'b0;
    reset = 1'b1;
    #1;
    n_total++;
    if (outs !== 16'h0000) $display("FAIL halt_reset got %h want %h", outs, 16'h0000);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++;
    if (outs !== E_F1) $display("FAIL halt_exit got %h want %h", outs, E_F1);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_alu_ops();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_mid_write();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style control FSM for the 8-bit multicycle CPU. It sequences the two-byte fetch, decode and execute steps. It drives every datapath enable and select consumed by the CPU top: memory write, PC update, address mux, IR1/IR2 latches, ALU operand selects, register write and ALU op. It sits directly upstream of the datapath. Its inputs are the opcode from IR1[7:4] and the ALU zero flag.

Parameters:
OPW, 4, opcode field width
ALUCW, 3, aluControl width

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
opcode  in  4  IR1[7:4], valid from DECODE onward
zero  in  1  ALU result == 0, combinational from datapath
memEnable  out  1  memory write enable
pcSelect  out  1  0 = ALU result, 1 = IR2 (absolute target)
pcEnable  out  1  PC register load
adrSelect  out  1  memory address: 0 = PC, 1 = IR2
ir1En  out  1  load IR1 from memRD
ir2En  out  1  load IR2 from memRD
op1Sel  out  1  ALU A: 0 = PC, 1 = regA
op2Sel  out  2  ALU B: 00 = regB, 01 = const 1, 10 = IR2, 11 = reserved (0)
regWrite  out  1  register file write
memToReg  out  1  write-back source: 0 = aluoutM, 1 = memRD
aluControl  out  3  ALU op
halted  out  1  high while in HALT
illegalOp  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). The state register is updated only on the rising edge of clk.
- Reset:
  - state <= FETCH1.
  - While reset is high, every output is forced to 0, aluControl = ADD.
  - Reset mid-instruction aborts it; no partial write occurs after the reset edge.
- Outputs are decoded from the state register. Exceptions:
  - aluControl in EXEC_R depends on opcode.
  - pcEnable in BRANCH depends on zero.
- Unlisted outputs are 0 in every state.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR (rd <- rd op rs)
  - 4 ADDI (rd <- rd + IR2)
  - 5 LB (rd <- mem[IR2])
  - 6 SB (mem[IR2] <- rs)
  - 7 BEQZ (if rs == 0, PC <- IR2)
  - 8 JMP (PC <- IR2)
  - F HALT
  - 9–E illegal
- aluControl codes: ADD 000, SUB 001, AND 010, OR 011, PASS_A 100.
- State table:
  - FETCH1: adrSelect=0, ir1En=1, op1Sel=0, op2Sel=01, ADD, pcSelect=0, pcEnable=1 -> FETCH2
  - FETCH2: same as FETCH1 but ir2En=1 instead of ir1En -> DECODE
  - DECODE: all enables 0. Dispatch: 0–3 -> EXEC_R; 4 -> EXEC_I; 5 -> MEM_RD; 6 -> MEM_WR; 7 -> BRANCH; 8 -> JUMP; F -> HALT; else illegalOp=1 -> FETCH1 (instruction acts as a NOP).
  - EXEC_R: op1Sel=1, op2Sel=00, aluControl=opcode[1:0] mapped to ADD/SUB/AND/OR -> ALU_WB
  - EXEC_I: op1Sel=1, op2Sel=10, ADD -> ALU_WB
  - ALU_WB: regWrite=1, memToReg=0 -> FETCH1
  - MEM_RD: adrSelect=1 -> LOAD_WB
  - LOAD_WB: adrSelect=1, regWrite=1, memToReg=1 -> FETCH1
  - MEM_WR: adrSelect=1, memEnable=1 (exactly one cycle) -> FETCH1
  - BRANCH: op1Sel=1, PASS_A, pcSelect=1, pcEnable=zero -> FETCH1
  - JUMP: pcSelect=1, pcEnable=1 -> FETCH1
  - HALT: halted=1, all enables 0; stays in HALT until reset.
- Cycles per instruction: ALU/ADDI/LB 5; SB/BEQZ/JMP 4; illegal 3.
- PC wraps 0xFF -> 0x00 through the 8-bit ALU; the controller does not track this.
- opcode is sampled only in DECODE and EXEC_R. IR1 is stable there because ir1En=0 outside FETCH1.
- memEnable and regWrite are never high in the same cycle.
- pcEnable is never high outside FETCH1, FETCH2, BRANCH and JUMP.

Decomposition:
- Shared package cpu_pkg holds:
  - state_t enum
  - opcode_t constants (OP_ADD … OP_HALT)
  - alu_op_t constants (ALU_ADD … ALU_PASS_A)
  - op2Sel encodings (OP2_REGB, OP2_ONE, OP2_IMM)
- One optional sub-module, alu_decoder: maps opcode to aluControl for EXEC_R. Everything else stays in the FSM.

Test Plan:
- Reset held 3 cycles then released: all outputs 0 during reset. First cycle after release shows FETCH1 outputs (ir1En=1, pcEnable=1, op2Sel=01, aluControl=000).
- opcode=1 (SUB): sequence FETCH1, FETCH2, DECODE, EXEC_R (aluControl=001, op1Sel=1, op2Sel=00), ALU_WB (regWrite=1, memToReg=0). Then back to FETCH1; total 5 cycles.
- opcode=6 (SB): memEnable=1 for exactly 1 cycle, 4 cycles after the fetch start, with adrSelect=1. Integrated with the CPU top, the first write carries memWD=4 for the standard program.
- opcode=7 (BEQZ) with zero=1: pcEnable=1 and pcSelect=1 in BRANCH. Repeat with zero=0: pcEnable=0. Next state is FETCH1 in both cases.
- opcode=F: halted=1 and all enables 0 for 20 cycles. Reset then returns to FETCH1. Also check opcode=A: illegalOp pulses for 1 cycle in DECODE, then FETCH1.
- Reset asserted during MEM_WR: memEnable=0 in that cycle. State is FETCH1 after the next edge.
